// File: rtl/mult_share_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_sched_if
// Purpose  : Request/response handshake bundle for the shared multiplier scheduler.
// Revision : 1.0
// ============================================================================
interface mult_share_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_product;

    // Requesters plus response consumer
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );
endinterface
`default_nettype wire

// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_sched
// Purpose  : Shares one combinational 16x16 multiplier among NREQ requesters;
//            optional macro MULT_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision : 1.0
// ============================================================================
module mult_share_sched #(
    parameter int NREQ       = 4,
    parameter int IDW        = $clog2(NREQ),
    parameter int SETTLE_CYC = 2
) (
    input  wire                      clk,
    input  wire                      rst_n,
    mult_share_sched_if.slave        bus,
    output logic [15:0]              mul_a,
    output logic [15:0]              mul_b,
    input  wire  [31:0]              mul_p,
    output logic                     busy
);

    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_settle = 2'd1;
    localparam logic [1:0] c_s_resp   = 2'd2;
    localparam logic [3:0] c_cnt_init = 4'(SETTLE_CYC - 1);
    localparam logic [NREQ-1:0] c_one = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [3:0]      r_cnt;
    logic [15:0]     r_mul_a;
    logic [15:0]     r_mul_b;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [31:0]     r_rsp_product;
    logic [IDW-1:0]  w_start;
    logic            w_grant_vld;
    logic [IDW-1:0]  w_grant_idx;
    logic [NREQ-1:0] w_req_ready;
    logic            w_busy;
    logic            w_accept;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Fixed priority: search always begins at requester 0
    assign w_start = '0;
`else
    logic [IDW-1:0] r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`endif

    // First valid requester at or after w_start, wrapping modulo NREQ
    always_comb begin
        int j;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        j           = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(w_start) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_grant_vld && bus.req_valid[IDW'(j)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDW'(j);
            end
        end
    end

    assign w_accept = (r_state == c_s_idle) && w_grant_vld;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_idle: begin
                if (w_grant_vld) begin
                    w_next = c_s_settle;
                end
            end
            c_s_settle: begin
                if (r_cnt == 4'd0) begin
                    w_next = c_s_resp;
                end
            end
            c_s_resp: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_next = c_s_idle;
                end
            end
            default: w_next = c_s_idle;
        endcase
    end

    // Output logic; ready is forced low while reset is held
    always_comb begin
        w_req_ready = '0;
        w_busy      = (r_state != c_s_idle);
        if ((r_state == c_s_idle) && w_grant_vld && rst_n) begin
            w_req_ready = c_one << w_grant_idx;
        end
    end

    // Operand, counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= 4'd0;
            r_mul_a       <= 16'd0;
            r_mul_b       <= 16'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= 32'd0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (w_accept) begin
                        r_mul_a  <= bus.req_a[16*w_grant_idx +: 16];
                        r_mul_b  <= bus.req_b[16*w_grant_idx +: 16];
                        r_rsp_id <= w_grant_idx;
                        r_cnt    <= c_cnt_init;
                    end
                end
                c_s_settle: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_product <= mul_p;
                        r_rsp_valid   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_s_resp: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_product = r_rsp_product;
    assign mul_a           = r_mul_a;
    assign mul_b           = r_mul_b;
    assign busy            = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_sched
// Purpose  : Self-checking bench for mult_share_sched (model + directed vectors).
// Revision : 1.0
// ============================================================================
module tb_mult_share_sched;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Main DUT (SETTLE_CYC = 2)
    mult_share_sched_if #(.NREQ(NREQ), .IDW(IDW)) dif ();
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_p;
    logic        busy;
    assign mul_p = {16'd0, mul_a} * {16'd0, mul_b};

    mult_share_sched #(.NREQ(NREQ), .IDW(IDW), .SETTLE_CYC(SETTLE)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(dif),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
    );

    // Throughput DUT (SETTLE_CYC = 1)
    mult_share_sched_if #(.NREQ(NREQ), .IDW(IDW)) dif1 ();
    logic [15:0] mul_a1, mul_b1;
    logic [31:0] mul_p1;
    logic        busy1;
    assign mul_p1 = {16'd0, mul_a1} * {16'd0, mul_b1};

    mult_share_sched #(.NREQ(NREQ), .IDW(IDW), .SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(dif1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1), .busy(busy1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: idle / counting down / waiting for consumer
    bit          m_idle  = 1'b1;
    int          m_left  = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    logic [15:0] m_a     = '0;
    logic [15:0] m_b     = '0;
    logic [31:0] m_prod  = '0;
    bit          m_valid = 1'b0;
    int          m_g;

    function automatic int grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ] === 1'b1) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_left = 0; m_ptr = 0; m_id = 0;
            m_a = '0; m_b = '0; m_prod = '0; m_valid = 1'b0;
        end else if (m_idle) begin
            m_g = grant(dif.req_valid, m_ptr);
            if (m_g >= 0) begin
                m_a    = dif.req_a[16*m_g +: 16];
                m_b    = dif.req_b[16*m_g +: 16];
                m_id   = m_g;
`ifdef MULT_ARB_FIXED_PRIO_EN
                m_ptr  = 0;
`else
                m_ptr  = (m_g + 1) % NREQ;
`endif
                m_left = SETTLE;
                m_idle = 1'b0;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_prod  = {16'd0, m_a} * {16'd0, m_b};
                m_valid = 1'b1;
            end
        end else if (dif.rsp_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // Per-cycle comparison against the model
    int          c_g;
    logic [3:0]  c_rdy;
    always @(negedge clk) begin
        c_g   = grant(dif.req_valid, m_ptr);
        c_rdy = (m_idle && rst_n === 1'b1 && c_g >= 0) ? (4'b0001 << c_g) : 4'b0000;
        check("req_ready",   dif.req_ready,   c_rdy);
        check("busy",        busy,            !m_idle);
        check("mul_a",       mul_a,           m_a);
        check("mul_b",       mul_b,           m_b);
        check("rsp_valid",   dif.rsp_valid,   m_valid);
        check("rsp_id",      dif.rsp_id,      m_id);
        check("rsp_product", dif.rsp_product, m_prod);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one request on an idle DUT; returns edges-to-rsp_valid and the response
    task automatic do_req(input int id, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [IDW-1:0] rid, output logic [31:0] prod);
        dif.req_a[16*id +: 16] = a;
        dif.req_b[16*id +: 16] = b;
        dif.req_valid[id]      = 1'b1;
        tick();
        dif.req_valid = '0;
        check("accepted", busy, 1'b1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (dif.rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check("rsp timeout", 32'd0, 32'd1);
        rid  = dif.rsp_id;
        prod = dif.rsp_product;
    endtask

    int             lat;
    logic [IDW-1:0] rid;
    logic [31:0]    prod;
    int             tacc [4];
    int             order [5];
    int             exp_order [5];
    bit             found;

    initial begin
        rst_n          = 1'b0;
        dif.req_valid  = 4'hF;
        dif.req_a      = '0;
        dif.req_b      = '0;
        dif.rsp_ready  = 1'b1;
        dif1.req_valid = '0;
        dif1.req_a     = '0;
        dif1.req_b     = '0;
        dif1.rsp_ready = 1'b1;
        repeat (3) tick();
        check("reset req_ready", dif.req_ready, 4'h0);
        check("reset busy",      busy,          1'b0);
        check("reset rsp_valid", dif.rsp_valid, 1'b0);
        check("reset mul_a",     mul_a,         16'h0);
        dif.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Throughput: one requester always valid on the SETTLE_CYC=1 instance
        dif1.req_a[15:0]  = 16'h0003;
        dif1.req_b[15:0]  = 16'h0005;
        dif1.req_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (dif1.req_ready[0] === 1'b1) begin
                    tacc[k] = cyc;
                    found   = 1'b1;
                    break;
                end
            end
            if (!found) check("throughput timeout", 32'd0, 32'd1);
            @(posedge clk);
        end
        #1 dif1.req_valid = '0;
        for (int k = 0; k < 3; k++) check("accept spacing", tacc[k+1] - tacc[k], 32'd3);
        check("thr product", dif1.rsp_product, 32'h0000000F);

        // Single request and extremes
        do_req(2, 16'h1234, 16'h5678, lat, rid, prod);
        check("single latency", lat, SETTLE);
        check("single id",      rid, 2);
        check("single product", prod, 32'h06260060);
        tick();
        check("single idle", busy, 1'b0);
        do_req(1, 16'hFFFF, 16'hFFFF, lat, rid, prod); tick();
        check("max product", prod, 32'hFFFE0001);
        do_req(3, 16'h0000, 16'hBEEF, lat, rid, prod); tick();
        check("zero product", prod, 32'h00000000);
        do_req(0, 16'h0001, 16'h8000, lat, rid, prod); tick();
        check("msb product", prod, 32'h00008000);

        // Back-pressure for 10 cycles with competing requesters
        dif.rsp_ready = 1'b0;
        do_req(3, 16'hA5A5, 16'h0003, lat, rid, prod);
        dif.req_valid = 4'b0111;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("bp rsp_valid",   dif.rsp_valid,   1'b1);
            check("bp rsp_id",      dif.rsp_id,      3);
            check("bp rsp_product", dif.rsp_product, 32'h0001F0EF);
            check("bp req_ready",   dif.req_ready,   4'h0);
            check("bp mul_a",       mul_a,           16'hA5A5);
            check("bp mul_b",       mul_b,           16'h0003);
        end
        dif.rsp_ready = 1'b1;
        dif.req_valid = '0;
        tick();
        check("bp release idle",  busy,          1'b0);
        check("bp release valid", dif.rsp_valid, 1'b0);

        // Reset while operands are settling
        dif.req_a[31:16]  = 16'h00FF;
        dif.req_b[31:16]  = 16'h0101;
        dif.req_valid[1]  = 1'b1;
        tick();
        dif.req_valid = '0;
        check("pre-reset mul_a", mul_a, 16'h00FF);
        #1 rst_n = 1'b0;
        #1;
        check("mid reset rsp_valid", dif.rsp_valid, 1'b0);
        check("mid reset busy",      busy,          1'b0);
        check("mid reset mul_a",     mul_a,         16'h0);
        check("mid reset mul_b",     mul_b,         16'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("no rsp after reset", dif.rsp_valid, 1'b0);
        end

        // Arbitration with all four requesters continuously valid
        for (int i = 0; i < NREQ; i++) begin
            dif.req_a[16*i +: 16] = 16'h1000 + 16'(i) * 16'h0111;
            dif.req_b[16*i +: 16] = 16'h0010 + 16'(i);
        end
        dif.req_valid = 4'hF;
`ifdef MULT_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int t = 0; t < 5; t++) begin
            order[t] = -1;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (|(dif.req_ready & dif.req_valid)) begin
                    for (int i = 0; i < NREQ; i++) if (dif.req_ready[i]) order[t] = i;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        dif.req_valid = '0;
        for (int t = 0; t < 5; t++) check("grant order", order[t], exp_order[t]);
        repeat (SETTLE + 3) tick();
        check("final idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/mult_share_sched.md
# mult_share_sched

Scheduler that shares one 16x16 combinational array multiplier between NREQ requesters. It arbitrates among valid/ready request ports and drives registered operands into the multiplier. Operands are held stable for a programmable number of settle cycles so the deep ripple partial-product chain can resolve. It then captures the 32-bit product and returns it with the requester's ID over a valid/ready response port.

## Interface
- NREQ, 4, number of requesters; legal 2..16.
- IDW, $clog2(NREQ), width of the requester ID.
- SETTLE_CYC, 2, cycles operands are held before product capture; legal 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  16*NREQ  operand A; requester i uses bits [16i+15:16i].
- req_b  input  16*NREQ  operand B; same packing as req_a.
- mul_a  output  16  registered operand A to the multiplier.
- mul_b  output  16  registered operand B to the multiplier.
- mul_p  input  32  unsigned product returned from the multiplier.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_product  output  32  captured product.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, SETTLE, RESP. Reset state is IDLE.
- IDLE:
  - The grant is computed combinationally from req_valid and rr_ptr.
  - req_ready is one-hot on the granted requester, or all zero when no requester is valid.
  - On a handshake (req_valid[g] & req_ready[g]), the edge loads mul_a, mul_b, rsp_id <= g and cnt <= SETTLE_CYC-1, and moves to SETTLE.
- SETTLE:
  - req_ready is all zero.
  - If cnt==0: rsp_product <= mul_p, rsp_valid <= 1, next state RESP.
  - Otherwise cnt decrements.
- RESP:
  - rsp_valid, rsp_id and rsp_product are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, next state IDLE.
- Round robin:
  - Search starts at index rr_ptr and wraps modulo NREQ.
  - On acceptance, rr_ptr <= (g+1) mod NREQ. An index of NREQ-1 wraps to 0.
- mul_a and mul_b change only on an accepted handshake and hold their value otherwise.
- The product is unsigned. No truncation is applied: the full 32 bits are passed through.
- A requester that deasserts req_valid before being granted is simply skipped; no request state is stored.

## Timing
- Reset values: req_ready=0 (during reset), mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0, rr_ptr=0, cnt=0.
- Latency: for a handshake at edge E, rsp_valid is high after edge E+SETTLE_CYC.
- mul_a and mul_b are stable for exactly SETTLE_CYC full cycles before capture.
- Minimum initiation interval is SETTLE_CYC+2 cycles, reached when rsp_ready is held high.
  - The next accept occurs at edge E+SETTLE_CYC+2.
- Back-pressure: rsp_ready low holds RESP for any number of cycles. No new request is accepted during that time.
- A rsp_ready that rises in the same cycle as rsp_valid completes the response at that edge.
- Reset asserted mid-operation aborts the in-flight operation with no response and returns all registers to their reset values immediately.

## Configuration
- MULT_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest-index valid requester always wins, and rr_ptr is not implemented (tied to 0).
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single request: NREQ=4, SETTLE_CYC=2, requester 2 sends a=0x1234, b=0x5678, rsp_ready=1.
  - Expect rsp_valid 2 edges after accept, with rsp_id=2 and rsp_product=0x06260060.
  - Expect req_ready=0 while busy.
- Extremes: a=0xFFFF, b=0xFFFF gives 0xFFFE0001. a=0, b=0xBEEF gives 0. a=1, b=0x8000 gives 0x00008000.
- Round robin: all four requesters hold req_valid with distinct operands.
  - Expect grant order 0,1,2,3,0 with each rsp_id/product matching its requester.
  - With MULT_ARB_FIXED_PRIO_EN defined, expect requester 0 granted on every accept.
- Back-pressure: hold rsp_ready=0 for 10 cycles in RESP.
  - Expect rsp_valid, rsp_id and rsp_product stable, req_ready=0 and mul_a/mul_b unchanged.
  - Release rsp_ready and expect IDLE on the next edge.
- Throughput: SETTLE_CYC=1, one requester continuously valid, rsp_ready=1.
  - Expect accepts exactly 3 cycles apart.
- Reset mid-op: assert rst_n=0 in SETTLE.
  - Expect rsp_valid=0, busy=0, mul_a=mul_b=0 immediately.
  - Expect no response after rst_n releases, and the first grant goes to requester 0.
